// File: rtl/audio_axi_pkg.sv
// rtl/audio_axi_pkg.sv - shared constants and types for the audio AXI4-Lite feeder
package audio_axi_pkg;

  localparam logic [31:0] CH_A_OFF  = 32'h0;
  localparam logic [31:0] CH_B_OFF  = 32'h4;
  localparam logic [1:0]  RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_A,
    ST_RESP_A,
    ST_ADDR_B,
    ST_RESP_B
  } state_t;

  typedef struct packed {
    logic signed [15:0] a;
    logic signed [15:0] b;
  } pair_t;

  function automatic logic [31:0] sext16(input logic [15:0] s);
    return {{16{s[15]}}, s};
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - synchronous sample-pair FIFO with wrap-bit pointers
module audio_sample_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] pop_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + PW'(1);
      if (pop && !empty) rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !full) mem[wptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rptr[AW-1:0]];
  assign empty    = (wptr == rptr);
  // Same slot index but different lap means the writer is a full lap ahead.
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/audio_axi4lite_feeder.sv
// rtl/audio_axi4lite_feeder.sv - paced AXI4-Lite writer feeding stereo PCM pairs
module audio_axi4lite_feeder
  import audio_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          TICK_DIV   = 1125,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sample_valid_i,
  input  logic [15:0] sample_a_i,
  input  logic [15:0] sample_b_i,
  output logic        sample_ready_o,
  output logic        m_awvalid_o,
  input  logic        m_awready_i,
  output logic [31:0] m_awaddr_o,
  output logic        m_wvalid_o,
  input  logic        m_wready_i,
  output logic [31:0] m_wdata_o,
  output logic [3:0]  m_wstrb_o,
  input  logic        m_bvalid_i,
  output logic        m_bready_o,
  input  logic [1:0]  m_bresp_i,
  output logic        underrun_o,
  output logic        err_o,
  output logic [15:0] miss_count_o
);

  if (TICK_DIV < 8) begin : g_bad_tick_div
    $error("TICK_DIV must be >= 8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  localparam int              CW      = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   CNT_MAX = CW'(TICK_DIV - 1);

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic          tick, pend, consume, drop, underrun;
  logic          aw_done, aw_done_d, w_done, w_done_d;
  logic          awvalid, wvalid, bready, ch_b;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, alive;
  pair_t         fifo_rdata, pair_q;
  logic [15:0]   miss_q;
  logic          err_q;

  assign tick = (cnt == CNT_MAX);
  assign drop = tick && pend && !consume;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt <= '0;
    else       cnt <= tick ? '0 : cnt + CW'(1);
  end

  // Ready is held low until the first clock after reset release.
  assign sample_ready_o = alive && !fifo_full;
  assign fifo_push      = sample_valid_i && sample_ready_o;

  audio_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (fifo_push),
    .push_data ({sample_a_i, sample_b_i}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d   = state;
    aw_done_d = aw_done;
    w_done_d  = w_done;
    consume   = 1'b0;
    fifo_pop  = 1'b0;
    underrun  = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend) begin
          consume = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ST_ADDR_A;
          end else begin
            underrun = 1'b1;
          end
        end
      end
      ST_ADDR_A, ST_ADDR_B: begin
        awvalid   = !aw_done;
        wvalid    = !w_done;
        aw_done_d = aw_done || (awvalid && m_awready_i);
        w_done_d  = w_done || (wvalid && m_wready_i);
        if (aw_done_d && w_done_d) begin
          state_d   = (state == ST_ADDR_A) ? ST_RESP_A : ST_RESP_B;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ST_RESP_A: begin
        bready = 1'b1;
        if (m_bvalid_i) state_d = ST_ADDR_B;
      end
      ST_RESP_B: begin
        bready = 1'b1;
        if (m_bvalid_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_d;
      aw_done <= aw_done_d;
      w_done  <= w_done_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend   <= 1'b0;
      pair_q <= '0;
      miss_q <= '0;
      err_q  <= 1'b0;
      alive  <= 1'b0;
    end else begin
      alive <= 1'b1;
      pend  <= tick || (pend && !consume);
      if (fifo_pop) pair_q <= fifo_rdata;
      if ((underrun || drop) && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
      if (bready && m_bvalid_i && m_bresp_i != RESP_OKAY) err_q <= 1'b1;
    end
  end

  // Address/data depend only on state and pair_q, so they stay stable while valid is held.
  assign ch_b         = (state == ST_ADDR_B) || (state == ST_RESP_B);
  assign m_awaddr_o   = (state == ST_IDLE) ? 32'h0 : BASE_ADDR + (ch_b ? CH_B_OFF : CH_A_OFF);
  assign m_wdata_o    = (state == ST_IDLE) ? 32'h0 : sext16(ch_b ? pair_q.b : pair_q.a);
  assign m_awvalid_o  = awvalid;
  assign m_wvalid_o   = wvalid;
  assign m_wstrb_o    = 4'hF;
  assign m_bready_o   = bready;
  assign underrun_o   = underrun;
  assign err_o        = err_q;
  assign miss_count_o = miss_q;

endmodule

// File: tb/tb_audio_axi4lite_feeder.sv
// tb/tb_audio_axi4lite_feeder.sv - self-checking bench for audio_axi4lite_feeder
module tb_audio_axi4lite_feeder;

  localparam int          TD    = 8;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        sample_valid_i = 1'b0;
  logic [15:0] sample_a_i = '0, sample_b_i = '0;
  logic        sample_ready_o;
  logic        m_awvalid_o, m_awready_i = 1'b0;
  logic [31:0] m_awaddr_o;
  logic        m_wvalid_o, m_wready_i = 1'b0;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_wstrb_o;
  logic        m_bvalid_i = 1'b0, m_bready_o;
  logic [1:0]  m_bresp_i = 2'b00;
  logic        underrun_o, err_o;
  logic [15:0] miss_count_o;

  audio_axi4lite_feeder #(.BASE_ADDR(BASE), .TICK_DIV(TD), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .sample_valid_i(sample_valid_i), .sample_a_i(sample_a_i), .sample_b_i(sample_b_i),
    .sample_ready_o(sample_ready_o),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i), .m_awaddr_o(m_awaddr_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i), .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
    .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o), .m_bresp_i(m_bresp_i),
    .underrun_o(underrun_o), .err_o(err_o), .miss_count_o(miss_count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0, n_total = 0;

  // reference model: tick schedule, pending flag, FIFO contents, expected write stream
  int          cyc, miss, pop_cyc, b_cnt;
  bit          pend, busy, err;
  logic [31:0] fq[$], exp_aw[$], exp_w[$], aw_log[$], w_log[$];
  // responder
  int          aw_stall, w_stall, b_delay, aw_seen, w_seen, b_wait;
  bit          aw_got, w_got, b_pending, rand_mode, zw_timing;
  logic [1:0]  bresp_cfg;
  // observation
  bit          prev_aw_wait, prev_w_wait;
  logic [31:0] prev_awaddr, prev_wdata;
  int          ur_seen, aw_hi_total, w_hi_total, aw_hs_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] sx(input logic [15:0] s);
    return {{16{s[15]}}, s};
  endfunction

  task automatic cycle();
    bit tick, consume, rdy_exp, aw_hs, w_hs, b_hs;
    logic [31:0] p, e;
    m_awready_i = (aw_seen >= aw_stall);
    m_wready_i  = (w_seen >= w_stall);
    m_bvalid_i  = b_pending && (b_wait >= b_delay);
    m_bresp_i   = m_bvalid_i ? bresp_cfg : 2'b00;
    #1;
    rdy_exp = (fq.size() < DEPTH);
    chk("sample_ready", sample_ready_o, rdy_exp);
    chk("underrun", underrun_o, (!busy && pend && fq.size() == 0));
    chk("miss_count", miss_count_o, miss);
    chk("err", err_o, err);
    if (m_bready_o) chk("bready_without_valids", {m_awvalid_o, m_wvalid_o}, 0);
    if (prev_aw_wait) begin
      chk("awvalid_hold", m_awvalid_o, 1);
      chk("awaddr_stable", m_awaddr_o, prev_awaddr);
    end
    if (prev_w_wait) begin
      chk("wvalid_hold", m_wvalid_o, 1);
      chk("wdata_stable", m_wdata_o, prev_wdata);
    end
    if (underrun_o) ur_seen++;
    if (m_awvalid_o) aw_hi_total++;
    if (m_wvalid_o) w_hi_total++;
    aw_hs = m_awvalid_o && m_awready_i;
    w_hs  = m_wvalid_o && m_wready_i;
    b_hs  = m_bvalid_i && m_bready_o;
    if (aw_hs) begin
      aw_hs_total++;
      aw_log.push_back(m_awaddr_o);
      if (exp_aw.size() == 0) chk("aw_unexpected", m_awvalid_o, 0);
      else begin
        if (zw_timing && exp_aw.size() == 2) chk("aw_a_latency", cyc, pop_cyc + 1);
        e = exp_aw.pop_front();
        chk("awaddr", m_awaddr_o, e);
      end
    end
    if (w_hs) begin
      w_log.push_back(m_wdata_o);
      chk("wstrb", m_wstrb_o, 4'hF);
      if (exp_w.size() == 0) chk("w_unexpected", m_wvalid_o, 0);
      else begin
        e = exp_w.pop_front();
        chk("wdata", m_wdata_o, e);
      end
    end
    // model step
    tick    = (cyc % TD) == TD - 1;
    consume = !busy && pend;
    if (consume) begin
      if (fq.size() > 0) begin
        p = fq.pop_front();
        exp_aw.push_back(BASE + 32'h0);
        exp_aw.push_back(BASE + 32'h4);
        exp_w.push_back(sx(p[31:16]));
        exp_w.push_back(sx(p[15:0]));
        busy = 1;
        pop_cyc = cyc;
      end else if (miss < 65535) miss++;
    end
    if (tick && pend && !consume && miss < 65535) miss++;
    pend = tick || (pend && !consume);
    if (sample_valid_i && rdy_exp) fq.push_back({sample_a_i, sample_b_i});
    if (b_hs) begin
      if (m_bresp_i != 2'b00) err = 1;
      b_cnt++;
      if (b_cnt % 2 == 0) begin
        busy = 0;
        if (zw_timing) chk("pair_done_latency", cyc, pop_cyc + 4);
      end
    end
    // responder step
    if (aw_hs) begin aw_seen = 0; aw_got = 1; end else if (m_awvalid_o) aw_seen++;
    if (w_hs) begin w_seen = 0; w_got = 1; end else if (m_wvalid_o) w_seen++;
    if (b_hs) begin
      b_pending = 0;
      if (rand_mode) begin
        aw_stall  = $urandom_range(0, 3);
        w_stall   = $urandom_range(0, 3);
        b_delay   = $urandom_range(0, 3);
        bresp_cfg = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      end
    end else if (b_pending) b_wait++;
    if (aw_got && w_got) begin
      aw_got = 0; w_got = 0; b_pending = 1; b_wait = 0;
    end
    prev_aw_wait = m_awvalid_o && !aw_hs;
    prev_w_wait  = m_wvalid_o && !w_hs;
    prev_awaddr  = m_awaddr_o;
    prev_wdata   = m_wdata_o;
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic do_reset(input bit check_async);
    rst_i = 1'b1;
    sample_valid_i = 1'b0;
    m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0; m_bresp_i = 2'b00;
    if (check_async) begin
      #1;
      chk("async_rst_awvalid", m_awvalid_o, 0);
      chk("async_rst_wvalid", m_wvalid_o, 0);
      chk("async_rst_bready", m_bready_o, 0);
    end
    fq.delete(); exp_aw.delete(); exp_w.delete();
    pend = 0; busy = 0; err = 0; miss = 0; b_cnt = 0;
    aw_seen = 0; w_seen = 0; b_wait = 0; aw_got = 0; w_got = 0; b_pending = 0;
    prev_aw_wait = 0; prev_w_wait = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rst_awvalid", m_awvalid_o, 0);
    chk("rst_wvalid", m_wvalid_o, 0);
    chk("rst_bready", m_bready_o, 0);
    chk("rst_awaddr", m_awaddr_o, 0);
    chk("rst_wdata", m_wdata_o, 0);
    chk("rst_underrun", underrun_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_miss", miss_count_o, 0);
    chk("rst_ready", sample_ready_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    cyc = 1;
  endtask

  task automatic run(input int n);
    sample_valid_i = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push_one(input logic [15:0] a, input logic [15:0] b);
    sample_valid_i = 1'b1; sample_a_i = a; sample_b_i = b;
    cycle();
    sample_valid_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pushed, budget, miss_before;
    bit saw_low, found;
    aw_stall = 0; w_stall = 0; b_delay = 0; bresp_cfg = 2'b00; rand_mode = 0; zw_timing = 0;
    @(negedge clk_i);
    do_reset(0);

    // empty FIFO on tick: single underrun, no AW traffic
    ur_seen = 0; aw_hs_total = 0;
    run(8);
    chk("underrun_pulses", ur_seen, 1);
    chk("miss_after_underrun", miss_count_o, 1);
    chk("no_aw_on_underrun", aw_hs_total, 0);

    // single pair against zero-wait responder
    aw_log.delete(); w_log.delete(); zw_timing = 1;
    push_one(16'h1234, 16'h8001);
    run(15);
    zw_timing = 0;
    chk("pair_aw_count", aw_log.size(), 2);
    if (aw_log.size() == 2 && w_log.size() == 2) begin
      chk("first_awaddr", aw_log[0], 32'h0);
      chk("first_wdata", w_log[0], 32'h0000_1234);
      chk("second_awaddr", aw_log[1], 32'h4);
      chk("second_wdata", w_log[1], 32'hFFFF_8001);
    end

    // FIFO fill: backpressure after DEPTH pairs, fifth accepted after a pop
    while (cyc % TD != 0) run(1);
    pushed = 0; saw_low = 0; budget = 0;
    while (pushed < 5 && budget < 20) begin
      sample_valid_i = 1'b1;
      sample_a_i = 16'h0100 + 16'(pushed);
      sample_b_i = 16'hF000 + 16'(pushed);
      if (!sample_ready_o) saw_low = 1;
      if (sample_ready_o) pushed++;
      cycle();
      budget++;
    end
    sample_valid_i = 1'b0;
    chk("fill_backpressure", saw_low, 1);
    chk("fill_all_accepted", pushed, 5);
    run(60);

    // awready stall of 3 cycles, wready immediate
    aw_hi_total = 0; w_hi_total = 0; aw_stall = 3;
    push_one(16'h7FFF, 16'h0042);
    run(30);
    chk("stall_aw_high_cycles", aw_hi_total, 8);
    chk("stall_w_high_cycles", w_hi_total, 2);
    aw_stall = 0;

    // slow responses with SLVERR: pend latched, ticks dropped, sticky error
    b_delay = 20; bresp_cfg = 2'b10; miss_before = miss;
    push_one(16'h1111, 16'h2222);
    push_one(16'h3333, 16'h4444);
    push_one(16'h5555, 16'h6666);
    run(150);
    chk("bresp_sets_err", err_o, 1);
    chk("dropped_ticks_counted", (miss_count_o > 16'(miss_before)), 1);
    b_delay = 0; bresp_cfg = 2'b00;
    run(60);
    chk("err_sticky", err_o, 1);

    // randomized traffic
    rand_mode = 1;
    for (int i = 0; i < 500; i++) begin
      sample_valid_i = ($urandom_range(0, 3) == 0);
      sample_a_i = 16'($urandom);
      sample_b_i = 16'($urandom);
      cycle();
    end
    rand_mode = 0;
    aw_stall = 0; w_stall = 0; b_delay = 0; bresp_cfg = 2'b00;
    run(80);

    // reset while channel B address phase is stalled
    aw_stall = 5;
    push_one(16'hABCD, 16'h1357);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_awvalid_o && exp_aw.size() == 1) found = 1;
      else cycle();
    end
    chk("reached_addr_b", found, 1);
    do_reset(1);
    aw_stall = 0;
    ur_seen = 0;
    run(12);
    chk("post_reset_underrun", ur_seen, 1);
    chk("post_reset_miss", miss_count_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
